// File: rtl/mdr_unit_pkg.sv
// mdr_pkg: shared definitions for the memory data register unit.
//   - Size encodings for byte / half / word transfers
//   - FSM state enum used by mdr_unit
//   - helpers deriving byte-offset and byte-enable widths from DATA_WIDTH
package mdr_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } mdrState_t;

    // Width of the byte-offset field; kept at least one bit so an 8-bit
    // datapath still has a legal port declaration.
    function automatic int offWidth(input int dataWidth);
        return (dataWidth > 8) ? $clog2(dataWidth / 8) : 1;
    endfunction

    function automatic int beWidth(input int dataWidth);
        return dataWidth / 8;
    endfunction

endpackage

// File: rtl/mdr_unit_if.sv
// mdr_unit_if: request/acknowledge bus between the MDR and data memory.
//   master (MDR side)    : drives MemReq, MemWe, MemBe, MemWData; reads MemRData, MemAck
//   slave  (memory side) : the mirror image
interface mdr_unit_if #(
    parameter int DATA_WIDTH = 32
);
    import mdr_pkg::*;

    localparam int BE_W = beWidth(DATA_WIDTH);

    logic                  MemReq;
    logic                  MemWe;
    logic [BE_W-1:0]       MemBe;
    logic [DATA_WIDTH-1:0] MemWData;
    logic [DATA_WIDTH-1:0] MemRData;
    logic                  MemAck;

    modport master (
        output MemReq, MemWe, MemBe, MemWData,
        input  MemRData, MemAck
    );

    modport slave (
        input  MemReq, MemWe, MemBe, MemWData,
        output MemRData, MemAck
    );

endinterface

// File: rtl/mdr_unit_lane_align.sv
// mdr_lane_align: purely combinational lane handling for mdr_unit.
//   write, size, signExt, byteOffset : command being formatted or completed
//   writeData : store source          -> storeData (lane replicated), byteEn
//   readRaw   : raw memory word       -> loadData (shifted, sign/zero extended)
//   legal     : command is encodable and naturally aligned
module mdr_lane_align
    import mdr_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int BE_W       = beWidth(DATA_WIDTH),
    localparam int OFF_W      = offWidth(DATA_WIDTH)
) (
    input  logic                  write,
    input  logic [1:0]            size,
    input  logic                  signExt,
    input  logic [OFF_W-1:0]      byteOffset,
    input  logic [DATA_WIDTH-1:0] writeData,
    input  logic [DATA_WIDTH-1:0] readRaw,
    output logic [DATA_WIDTH-1:0] storeData,
    output logic [BE_W-1:0]       byteEn,
    output logic [DATA_WIDTH-1:0] loadData,
    output logic                  legal
);

    // Top bit of a halfword, clamped so an 8-bit datapath still elaborates.
    localparam int HALF_MSB = (DATA_WIDTH >= 16) ? 15 : DATA_WIDTH - 1;

    logic [15:0]           half16;
    logic [OFF_W+2:0]      shiftAmt;
    logic [DATA_WIDTH-1:0] shifted;

    // Halves must sit on even offsets and words on offset zero; size 11 is reserved.
    always_comb begin
        legal = 1'b1;
        case (size)
            SZ_BYTE: legal = 1'b1;
            SZ_HALF: legal = ~byteOffset[0];
            SZ_WORD: legal = (byteOffset == '0);
            default: legal = 1'b0;
        endcase
    end

    // Stores replicate the narrow value across every lane so memory only
    // needs the byte enables to pick the right bytes; loads enable all lanes.
    always_comb begin
        half16    = 16'(writeData);
        storeData = writeData;
        byteEn    = '1;
        if (write) begin
            case (size)
                SZ_BYTE: begin
                    for (int i = 0; i < BE_W; i++) begin
                        storeData[i*8 +: 8] = writeData[7:0];
                    end
                    byteEn = BE_W'(1) << byteOffset;
                end
                SZ_HALF: begin
                    for (int i = 0; i < BE_W; i++) begin
                        storeData[i*8 +: 8] = half16[(i % 2)*8 +: 8];
                    end
                    byteEn = BE_W'(3) << byteOffset;
                end
                default: ;
            endcase
        end
    end

    // Bring the addressed byte/half down to bit 0.
    always_comb begin
        shiftAmt = {byteOffset, 3'b000};
        shifted  = readRaw >> shiftAmt;
    end

    // Bits above the loaded width become copies of its top bit (sign) or zero.
    always_comb begin
        loadData = shifted;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            case (size)
                SZ_BYTE: if (i >= 8)        loadData[i] = signExt & shifted[7];
                SZ_HALF: if (i > HALF_MSB)  loadData[i] = signExt & shifted[HALF_MSB];
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mdr_unit.sv
// mdr_unit: parametrised memory data register between CPU datapath and memory.
//   Clk, Rst (async, active low)
//   Enable/Write/Size/SignExt/ByteOffset/WriteData : command, sampled when idle
//   ReadData : aligned/extended load result, held until the next load completes
//   mem      : mdr_unit_if master port (MemReq/MemWe/MemBe/MemWData/MemRData/MemAck)
//   Busy, Done (one-cycle pulse), Error (sticky until next legal command)
module mdr_unit
    import mdr_pkg::*;
#(
    parameter  int DATA_WIDTH     = 32,
    parameter  int TIMEOUT_CYCLES = 15,
    localparam int BE_W           = beWidth(DATA_WIDTH),
    localparam int OFF_W          = offWidth(DATA_WIDTH)
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Enable,
    input  logic                  Write,
    input  logic [1:0]            Size,
    input  logic                  SignExt,
    input  logic [OFF_W-1:0]      ByteOffset,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    mdr_unit_if.master            mem,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);

    // The counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    mdrState_t state;
    mdrState_t nextState;

    logic                  writeQ;
    logic [1:0]            sizeQ;
    logic                  signExtQ;
    logic [OFF_W-1:0]      offQ;
    logic [CNT_W-1:0]      waitCnt;
    logic                  doneQ;
    logic                  memWeQ;
    logic [BE_W-1:0]       memBeQ;
    logic [DATA_WIDTH-1:0] memWDataQ;
    logic                  timedOut;

    logic                  alWrite;
    logic [1:0]            alSize;
    logic                  alSignExt;
    logic [OFF_W-1:0]      alOff;
    logic [DATA_WIDTH-1:0] storeData;
    logic [BE_W-1:0]       byteEn;
    logic [DATA_WIDTH-1:0] loadData;
    logic                  legal;

    // The aligner formats the live command while idle and the latched
    // command while waiting, so one instance serves both store and load.
    always_comb begin
        alWrite   = Write;
        alSize    = Size;
        alSignExt = SignExt;
        alOff     = ByteOffset;
        if (state == ST_WAIT) begin
            alWrite   = writeQ;
            alSize    = sizeQ;
            alSignExt = signExtQ;
            alOff     = offQ;
        end
    end

    mdr_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) laneAlign (
        .write      (alWrite),
        .size       (alSize),
        .signExt    (alSignExt),
        .byteOffset (alOff),
        .writeData  (WriteData),
        .readRaw    (mem.MemRData),
        .storeData  (storeData),
        .byteEn     (byteEn),
        .loadData   (loadData),
        .legal      (legal)
    );

    // An ack on the last allowed cycle wins over the timeout.
    always_comb begin
        timedOut = 1'b0;
        if (TIMEOUT_CYCLES > 0) begin
            timedOut = (state == ST_WAIT) && !mem.MemAck &&
                       (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: illegal commands take a one-cycle detour through FAULT
    // so they still produce a Done pulse without touching memory.
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE:  if (Enable) nextState = legal ? ST_WAIT : ST_FAULT;
            ST_WAIT:  if (mem.MemAck || timedOut) nextState = ST_IDLE;
            ST_FAULT: nextState = ST_IDLE;
            default:  nextState = ST_IDLE;
        endcase
    end

    // Outputs: MemReq/Busy follow WAIT directly so an async reset drops them
    // at once; Done covers both normal completion and the FAULT cycle.
    always_comb begin
        mem.MemReq = (state == ST_WAIT);
        Busy       = (state == ST_WAIT);
        Done       = doneQ || (state == ST_FAULT);
    end

    assign mem.MemWe    = memWeQ;
    assign mem.MemBe    = memBeQ;
    assign mem.MemWData = memWDataQ;

    // Command latch, bus drive registers, timeout counter and result registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            writeQ    <= 1'b0;
            sizeQ     <= SZ_BYTE;
            signExtQ  <= 1'b0;
            offQ      <= '0;
            waitCnt   <= '0;
            doneQ     <= 1'b0;
            memWeQ    <= 1'b0;
            memBeQ    <= '0;
            memWDataQ <= '0;
            ReadData  <= '0;
            Error     <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Enable) begin
                        if (legal) begin
                            writeQ    <= Write;
                            sizeQ     <= Size;
                            signExtQ  <= SignExt;
                            offQ      <= ByteOffset;
                            memWeQ    <= Write;
                            memBeQ    <= byteEn;
                            memWDataQ <= storeData;
                            waitCnt   <= '0;
                            Error     <= 1'b0;
                        end else begin
                            Error <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem.MemAck) begin
                        doneQ <= 1'b1;
                        if (!writeQ) begin
                            ReadData <= loadData;
                        end
                    end else if (timedOut) begin
                        doneQ <= 1'b1;
                        Error <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdr_unit.sv
// tb_mdr_unit: self-checking bench for mdr_unit (DATA_WIDTH=32, TIMEOUT_CYCLES=15).
// A behavioural model (arithmetic on byte offsets/sizes) predicts bus fields,
// load results and error flags; each test task checks its own scenario.
module tb_mdr_unit;
    import mdr_pkg::*;

    localparam int DW = 32;
    localparam int TO = 15;
    localparam int WINDOW = 40;

    logic        Clk;
    logic        Rst;
    logic        Enable;
    logic        Write;
    logic [1:0]  Size;
    logic        SignExt;
    logic [1:0]  ByteOffset;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Busy;
    logic        Done;
    logic        Error;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [31:0] expReadData;

    int          obsReqCycles;
    int          obsDoneCount;
    int          obsFirstDone;
    logic        obsStable;
    logic        obsWe;
    logic [3:0]  obsBe;
    logic [31:0] obsWData;
    logic        obsErrC1;
    logic        obsBusyEnd;

    mdr_unit_if #(.DATA_WIDTH(DW)) memBus ();

    mdr_unit #(
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Enable     (Enable),
        .Write      (Write),
        .Size       (Size),
        .SignExt    (SignExt),
        .ByteOffset (ByteOffset),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .mem        (memBus),
        .Busy       (Busy),
        .Done       (Done),
        .Error      (Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model ------------------------------------------------------
    function automatic logic isLegal(input logic [1:0] sz, input logic [1:0] off);
        if (sz == 2'd3) return 1'b0;
        if (sz == 2'd1 && (off % 2) != 0) return 1'b0;
        if (sz == 2'd2 && off != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] refBe(input logic wr, input logic [1:0] sz, input logic [1:0] off);
        if (!wr || sz == 2'd2) return 4'hF;
        if (sz == 2'd0) return 4'(1 << off);
        return 4'(3 << off);
    endfunction

    function automatic logic [31:0] refWData(input logic [1:0] sz, input logic [31:0] wd);
        if (sz == 2'd0) return 32'(wd[7:0]) * 32'h0101_0101;
        if (sz == 2'd1) return 32'(wd[15:0]) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] refLoad(input logic [1:0] sz, input logic sx,
                                            input logic [1:0] off, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * off);
        if (sz == 2'd0) begin
            v = v % 256;
            if (sx && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = v % 65536;
            if (sx && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Drives one command, then watches a fixed window recording what the bus
    // and handshake did. ackAfter = request cycle on which MemAck is offered
    // (0 = never). junk = hold Enable with garbage while the unit is busy.
    task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic sx,
                                 input logic [1:0] off, input logic [31:0] wd,
                                 input logic [31:0] rd, input int ackAfter, input logic junk);
        obsReqCycles = 0;
        obsDoneCount = 0;
        obsFirstDone = -1;
        obsStable    = 1'b1;
        obsWe        = 1'b0;
        obsBe        = 4'h0;
        obsWData     = 32'h0;
        obsErrC1     = 1'b0;
        @(negedge Clk);
        Enable     = 1'b1;
        Write      = wr;
        Size       = sz;
        SignExt    = sx;
        ByteOffset = off;
        WriteData  = wd;
        memBus.MemAck = 1'b0;
        @(negedge Clk);
        Enable = 1'b0;
        for (int c = 1; c <= WINDOW; c++) begin
            if (c == 1) obsErrC1 = Error;
            if (memBus.MemReq === 1'b1) begin
                if (obsReqCycles == 0) begin
                    obsWe    = memBus.MemWe;
                    obsBe    = memBus.MemBe;
                    obsWData = memBus.MemWData;
                end else if (memBus.MemWe !== obsWe || memBus.MemBe !== obsBe ||
                             memBus.MemWData !== obsWData) begin
                    obsStable = 1'b0;
                end
                obsReqCycles++;
            end
            if (Done === 1'b1) begin
                obsDoneCount++;
                if (obsFirstDone < 0) obsFirstDone = c;
            end
            Enable     = junk && (c <= ackAfter);
            Write      = 1'($urandom);
            Size       = 2'($urandom);
            SignExt    = 1'($urandom);
            ByteOffset = 2'($urandom);
            WriteData  = $urandom;
            memBus.MemAck   = (c == ackAfter);
            memBus.MemRData = (c == ackAfter) ? rd : $urandom;
            @(negedge Clk);
        end
        memBus.MemAck = 1'b0;
        Enable        = 1'b0;
        obsBusyEnd    = Busy;
    endtask

    // Tests ----------------------------------------------------------------
    task automatic test_reset();
        int reqSeen;
        Rst = 1'b0;
        repeat (3) begin
            Enable = 1'($urandom); Write = 1'($urandom); Size = 2'($urandom);
            SignExt = 1'($urandom); ByteOffset = 2'($urandom); WriteData = $urandom;
            memBus.MemAck = 1'($urandom); memBus.MemRData = $urandom;
            @(negedge Clk);
        end
        testsRun++; if (ReadData !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_ReadData: got %h expected 0", ReadData); end
        testsRun++; if (memBus.MemReq !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_MemReq: got %b expected 0", memBus.MemReq); end
        testsRun++; if (memBus.MemWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_MemWe: got %b expected 0", memBus.MemWe); end
        testsRun++; if (memBus.MemBe !== 4'h0) begin testsFailed++; $display("[TB] FAIL reset_MemBe: got %h expected 0", memBus.MemBe); end
        testsRun++; if (memBus.MemWData !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_MemWData: got %h expected 0", memBus.MemWData); end
        testsRun++; if (Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_Busy: got %b expected 0", Busy); end
        testsRun++; if (Done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_Done: got %b expected 0", Done); end
        testsRun++; if (Error !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_Error: got %b expected 0", Error); end
        Enable = 1'b0;
        memBus.MemAck = 1'b0;
        Rst = 1'b1;
        reqSeen = 0;
        repeat (20) begin
            @(negedge Clk);
            if (memBus.MemReq !== 1'b0) reqSeen++;
        end
        testsRun++; if (reqSeen != 0) begin testsFailed++; $display("[TB] FAIL idle_no_req: got %0d req cycles expected 0", reqSeen); end
        expReadData = 32'h0;
    endtask

    task automatic test_word_load();
        applyStimulus(1'b0, SZ_WORD, 1'b0, 2'd0, $urandom, 32'hDEAD_BEEF, 3, 1'b0);
        expReadData = 32'hDEAD_BEEF;
        testsRun++; if (obsBe !== 4'hF) begin testsFailed++; $display("[TB] FAIL word_load_be: got %h expected f", obsBe); end
        testsRun++; if (obsWe !== 1'b0) begin testsFailed++; $display("[TB] FAIL word_load_we: got %b expected 0", obsWe); end
        testsRun++; if (obsReqCycles != 3) begin testsFailed++; $display("[TB] FAIL word_load_req: got %0d expected 3", obsReqCycles); end
        testsRun++; if (obsDoneCount != 1 || obsFirstDone != 4) begin testsFailed++; $display("[TB] FAIL word_load_done: got %0d pulses at %0d expected 1 at 4", obsDoneCount, obsFirstDone); end
        testsRun++; if (ReadData !== expReadData) begin testsFailed++; $display("[TB] FAIL word_load_data: got %h expected %h", ReadData, expReadData); end
        testsRun++; if (obsBusyEnd !== 1'b0 || !obsStable) begin testsFailed++; $display("[TB] FAIL word_load_busy_stable: got busy %b stable %b expected 0 1", obsBusyEnd, obsStable); end
    endtask

    task automatic test_byte_load();
        applyStimulus(1'b0, SZ_BYTE, 1'b1, 2'd2, $urandom, 32'h1280_3456, 1, 1'b0);
        testsRun++; if (ReadData !== 32'hFFFF_FF80) begin testsFailed++; $display("[TB] FAIL byte_load_sext: got %h expected ffffff80", ReadData); end
        testsRun++; if (obsFirstDone != 2) begin testsFailed++; $display("[TB] FAIL byte_load_zero_wait: got done at %0d expected 2", obsFirstDone); end
        applyStimulus(1'b0, SZ_BYTE, 1'b0, 2'd2, $urandom, 32'h1280_3456, 2, 1'b0);
        expReadData = 32'h0000_0080;
        testsRun++; if (ReadData !== expReadData) begin testsFailed++; $display("[TB] FAIL byte_load_zext: got %h expected %h", ReadData, expReadData); end
    endtask

    task automatic test_half_store();
        applyStimulus(1'b1, SZ_HALF, 1'($urandom), 2'd2, 32'hAAAA_1234, $urandom, 2, 1'b0);
        testsRun++; if (obsWe !== 1'b1) begin testsFailed++; $display("[TB] FAIL half_store_we: got %b expected 1", obsWe); end
        testsRun++; if (obsBe !== 4'b1100) begin testsFailed++; $display("[TB] FAIL half_store_be: got %b expected 1100", obsBe); end
        testsRun++; if (obsWData !== 32'h1234_1234) begin testsFailed++; $display("[TB] FAIL half_store_wdata: got %h expected 12341234", obsWData); end
        testsRun++; if (ReadData !== expReadData) begin testsFailed++; $display("[TB] FAIL half_store_readdata: got %h expected %h", ReadData, expReadData); end
    endtask

    task automatic test_illegal();
        applyStimulus(1'b0, SZ_WORD, 1'b0, 2'd1, $urandom, $urandom, 1, 1'b0);
        testsRun++; if (obsReqCycles != 0) begin testsFailed++; $display("[TB] FAIL illegal_req: got %0d expected 0", obsReqCycles); end
        testsRun++; if (Error !== 1'b1) begin testsFailed++; $display("[TB] FAIL illegal_error: got %b expected 1", Error); end
        testsRun++; if (obsDoneCount != 1 || obsFirstDone != 1) begin testsFailed++; $display("[TB] FAIL illegal_done: got %0d pulses at %0d expected 1 at 1", obsDoneCount, obsFirstDone); end
        testsRun++; if (ReadData !== expReadData) begin testsFailed++; $display("[TB] FAIL illegal_readdata: got %h expected %h", ReadData, expReadData); end
        applyStimulus(1'b0, SZ_BYTE, 1'b0, 2'd0, $urandom, 32'h0000_0042, 2, 1'b0);
        expReadData = 32'h0000_0042;
        testsRun++; if (obsErrC1 !== 1'b0) begin testsFailed++; $display("[TB] FAIL illegal_error_clear: got %b expected 0", obsErrC1); end
        testsRun++; if (ReadData !== expReadData) begin testsFailed++; $display("[TB] FAIL illegal_next_load: got %h expected %h", ReadData, expReadData); end
    endtask

    task automatic test_timeout();
        logic [31:0] rd;
        applyStimulus(1'b0, SZ_BYTE, 1'b1, 2'd3, $urandom, $urandom, 0, 1'b0);
        testsRun++; if (obsReqCycles != TO) begin testsFailed++; $display("[TB] FAIL timeout_req: got %0d expected %0d", obsReqCycles, TO); end
        testsRun++; if (Error !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_error: got %b expected 1", Error); end
        testsRun++; if (obsDoneCount != 1 || obsFirstDone != TO + 1) begin testsFailed++; $display("[TB] FAIL timeout_done: got %0d pulses at %0d expected 1 at %0d", obsDoneCount, obsFirstDone, TO + 1); end
        testsRun++; if (ReadData !== expReadData) begin testsFailed++; $display("[TB] FAIL timeout_readdata: got %h expected %h", ReadData, expReadData); end
        rd = $urandom;
        applyStimulus(1'b0, SZ_WORD, 1'b0, 2'd0, $urandom, rd, TO, 1'b0);
        expReadData = rd;
        testsRun++; if (Error !== 1'b0 || obsReqCycles != TO) begin testsFailed++; $display("[TB] FAIL late_ack: got error %b req %0d expected 0 %0d", Error, obsReqCycles, TO); end
        testsRun++; if (ReadData !== expReadData) begin testsFailed++; $display("[TB] FAIL late_ack_data: got %h expected %h", ReadData, expReadData); end
    endtask

    task automatic test_reset_mid_wait();
        int doneSeen;
        @(negedge Clk);
        Enable = 1'b1; Write = 1'b0; Size = SZ_WORD; SignExt = 1'b0; ByteOffset = 2'd0;
        memBus.MemAck = 1'b0;
        @(negedge Clk);
        Enable = 1'b0;
        repeat (2) @(negedge Clk);
        testsRun++; if (memBus.MemReq !== 1'b1) begin testsFailed++; $display("[TB] FAIL midwait_req_before: got %b expected 1", memBus.MemReq); end
        #2 Rst = 1'b0;
        #1;
        testsRun++; if (memBus.MemReq !== 1'b0 || Busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL midwait_req_drop: got req %b busy %b expected 0 0", memBus.MemReq, Busy); end
        doneSeen = 0;
        repeat (3) begin @(negedge Clk); if (Done !== 1'b0) doneSeen++; end
        Rst = 1'b1;
        repeat (5) begin @(negedge Clk); if (Done !== 1'b0) doneSeen++; end
        expReadData = 32'h0;
        testsRun++; if (doneSeen != 0) begin testsFailed++; $display("[TB] FAIL midwait_no_done: got %0d done cycles expected 0", doneSeen); end
        testsRun++; if (ReadData !== expReadData) begin testsFailed++; $display("[TB] FAIL midwait_readdata: got %h expected %h", ReadData, expReadData); end
    endtask

    task automatic test_ack_while_idle();
        int doneSeen;
        doneSeen = 0;
        repeat (3) begin
            memBus.MemAck = 1'b1;
            memBus.MemRData = $urandom;
            @(negedge Clk);
            if (Done !== 1'b0) doneSeen++;
        end
        memBus.MemAck = 1'b0;
        @(negedge Clk);
        testsRun++; if (doneSeen != 0 || ReadData !== expReadData) begin testsFailed++; $display("[TB] FAIL idle_ack: got done %0d data %h expected 0 %h", doneSeen, ReadData, expReadData); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        rd = $urandom;
        applyStimulus(1'b0, SZ_HALF, 1'b1, 2'd0, $urandom, rd, 4, 1'b1);
        expReadData = refLoad(SZ_HALF, 1'b1, 2'd0, rd);
        testsRun++; if (obsReqCycles != 4 || obsDoneCount != 1) begin testsFailed++; $display("[TB] FAIL busy_enable: got req %0d done %0d expected 4 1", obsReqCycles, obsDoneCount); end
        testsRun++; if (ReadData !== expReadData || Error !== 1'b0) begin testsFailed++; $display("[TB] FAIL busy_enable_data: got %h err %b expected %h 0", ReadData, Error, expReadData); end
    endtask

    task automatic test_random();
        logic        wr, sx, lg;
        logic [1:0]  sz, off;
        logic [31:0] wd, rd;
        int          ack;
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom); sx = 1'($urandom);
            sz = 2'($urandom_range(0, 3)); off = 2'($urandom);
            wd = $urandom; rd = $urandom;
            ack = $urandom_range(1, 6);
            lg = isLegal(sz, off);
            applyStimulus(wr, sz, sx, off, wd, rd, ack, 1'b0);
            if (lg && !wr) expReadData = refLoad(sz, sx, off, rd);
            testsRun++; if (obsReqCycles != (lg ? ack : 0)) begin testsFailed++; $display("[TB] FAIL rand_req[%0d]: got %0d expected %0d", n, obsReqCycles, lg ? ack : 0); end
            testsRun++; if (Error !== !lg || obsDoneCount != 1) begin testsFailed++; $display("[TB] FAIL rand_status[%0d]: got err %b done %0d expected %b 1", n, Error, obsDoneCount, !lg); end
            testsRun++; if (ReadData !== expReadData) begin testsFailed++; $display("[TB] FAIL rand_readdata[%0d]: got %h expected %h", n, ReadData, expReadData); end
            if (lg) begin
                testsRun++; if (obsWe !== wr || obsBe !== refBe(wr, sz, off) || !obsStable) begin testsFailed++; $display("[TB] FAIL rand_bus[%0d]: got we %b be %h stable %b expected %b %h 1", n, obsWe, obsBe, obsStable, wr, refBe(wr, sz, off)); end
                if (wr) begin
                    testsRun++; if (obsWData !== refWData(sz, wd)) begin testsFailed++; $display("[TB] FAIL rand_wdata[%0d]: got %h expected %h", n, obsWData, refWData(sz, wd)); end
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_illegal();
        test_timeout();
        test_reset_mid_wait();
        test_ack_while_idle();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mdr_unit.md
Name: mdr_unit

Overview:
- Parametrised memory data register: successor to the fixed 32-bit enable-gated MDR.
- Sits between CPU datapath/control and data memory.
- Issues one memory transfer per command using a req/ack handshake with timeout.
- Formats store data into byte lanes with byte enables; aligns and sign/zero-extends load data, holding the result in ReadData until the next load completes.

Parameters:
DATA_WIDTH, 32, datapath/memory word width; multiple of 8, power of two
TIMEOUT_CYCLES, 15, max cycles MemReq stays high waiting for MemAck; 0 disables timeout

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous, active-low reset
Enable  input  1  command strobe; sampled only when idle
Write  input  1  1 = store, 0 = load
Size  input  2  00 byte, 01 half, 10 word (DATA_WIDTH), 11 reserved
SignExt  input  1  load extension: 1 sign, 0 zero
ByteOffset  input  OFF_W = log2(DATA_WIDTH/8)  byte address low bits
WriteData  input  DATA_WIDTH  store source from register file
ReadData  output  DATA_WIDTH  aligned/extended load result, held
MemReq  output  1  transfer request to memory
MemWe  output  1  write enable, valid while MemReq
MemBe  output  DATA_WIDTH/8  byte enables, valid while MemReq
MemWData  output  DATA_WIDTH  lane-replicated store data
MemRData  input  DATA_WIDTH  memory read data, valid with MemAck
MemAck  input  1  memory completion
Busy  output  1  command in progress
Done  output  1  one-cycle completion pulse
Error  output  1  sticky fault flag

Behaviour:
- Reset (Rst=0, asynchronous): state IDLE; ReadData, MemReq, MemWe, MemBe, MemWData, Busy, Done, Error, timeout counter all 0.
- Reset mid-transfer: MemReq drops immediately; no Done pulse.
- FSM states: IDLE, WAIT, FAULT.
- IDLE, Enable=1 sampled at edge N, legal command:
  - latch Write/Size/SignExt/ByteOffset; clear Error.
  - drive MemReq=1, MemWe, MemBe, MemWData and Busy=1 from after edge N; go WAIT.
- Illegal command: Size=11, half with odd offset, or word with offset≠0.
  - set Error; no MemReq; go FAULT.
  - FAULT: Done=1 for one cycle, Busy=0, return to IDLE; ReadData unchanged.
- WAIT:
  - MemReq, MemWe, MemBe, MemWData held stable until MemAck is sampled high.
  - On MemAck: load -> ReadData <= extract(MemRData); store -> ReadData unchanged.
  - Next cycle: MemReq=0, Busy=0, Done=1 for one cycle, state IDLE.
  - Zero-wait memory (ack in first req cycle) completes in 2 cycles.
- Timeout (TIMEOUT_CYCLES>0):
  - counter increments each WAIT cycle without ack.
  - After TIMEOUT_CYCLES req cycles with no ack: abort, MemReq=0, Error=1, Done pulse, IDLE.
  - Ack on the final timeout cycle counts as success.
- Ignored events: Enable while Busy; MemAck while IDLE.
- Error is sticky; cleared only by the next accepted legal command.
- Store formatting:
  - byte: WriteData[7:0] replicated on all lanes; MemBe one-hot at ByteOffset.
  - half: WriteData[15:0] replicated; MemBe two bits at ByteOffset.
  - word: WriteData as-is; MemBe all ones.
  - Load commands drive MemBe all ones, MemWe=0.
- Load extract: MemRData >> (8*ByteOffset), keep 8/16/DATA_WIDTH bits, sign- or zero-extend to DATA_WIDTH.
- Latency: Enable edge N -> Done earliest in cycle after edge N+1.

Decomposition:
- Package mdr_pkg: Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state enum, OFF_W/BE_W derivation function.
- One combinational sub-module mdr_lane_align: store replication, byte-enable generation, load extract/extend, legality check.
- mdr_unit holds the FSM, timeout counter and registers.

Test Plan:
- Rst=0 with random inputs -> all outputs 0; release with Enable=0 -> MemReq stays 0 for 20 cycles.
- Word load, offset 0; MemAck after 3 cycles, MemRData=0xDEADBEEF -> MemBe=4'hF, MemWe=0, ReadData=0xDEADBEEF, single Done pulse, Busy low after.
- Byte load, offset 2, MemRData=0x12803456 -> SignExt=1 gives ReadData=0xFFFFFF80; SignExt=0 gives 0x00000080.
- Half store, offset 2, WriteData=0xAAAA1234 -> MemWe=1, MemBe=4'b1100, MemWData=0x12341234; ReadData unchanged.
- Word, offset 1 -> no MemReq, Error=1, one Done pulse; next legal command clears Error at acceptance.
- No MemAck, TIMEOUT_CYCLES=15 -> MemReq high exactly 15 cycles, then Error=1 and Done; separate run with Rst=0 mid-WAIT -> MemReq low immediately, no Done.
